// File: rtl/combi_enc_pkg.sv
// Shared types and encoding constants for the dual-ISA instruction encoder.
package combi_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLT   = 4'd4,
        OP_ADDI  = 4'd5,
        OP_ANDI  = 4'd6,
        OP_ORI   = 4'd7,
        OP_LOAD  = 4'd8,
        OP_STORE = 4'd9,
        OP_BEQ   = 4'd10,
        OP_JAL   = 4'd11,
        OP_LUI   = 4'd12
    } op_t;

    // RISC-V major opcodes
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // RISC-V funct fields
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    // ARM fields
    localparam logic [3:0] ARM_COND = 4'b1110;
    localparam logic [3:0] CMD_ADD  = 4'b0100;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0000;
    localparam logic [3:0] CMD_ORR  = 4'b1100;
    localparam logic [7:0] ARM_LDR  = 8'b01011001;
    localparam logic [7:0] ARM_STR  = 8'b01011000;
    localparam logic [3:0] ARM_B    = 4'b1010;

    typedef struct packed {
        logic [31:0] instr;
        logic        arm;
        logic        err;
    } fifo_entry_t;

    // Signed range test on a 32-bit immediate
    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/combi_enc_word.sv
// Pure combinational encoder: one request in, one instruction word plus error flag out.
module combi_enc_word
    import combi_enc_pkg::*;
(
    input  logic        arm,
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    op_t opc;
    assign opc = op_t'(op);

    // Build the word for the selected ISA; any error forces the word to zero.
    always_comb begin
        logic [31:0] w;
        logic        e;
        w = '0;
        e = 1'b0;
        if (!arm) begin
            case (opc)
                OP_ADD:   w = {7'b0, rs2, rs1, F3_ADD, rd, OPC_RTYPE};
                OP_SUB:   w = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_RTYPE};
                OP_AND:   w = {7'b0, rs2, rs1, F3_AND, rd, OPC_RTYPE};
                OP_OR:    w = {7'b0, rs2, rs1, F3_OR, rd, OPC_RTYPE};
                OP_SLT:   w = {7'b0, rs2, rs1, F3_SLT, rd, OPC_RTYPE};
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    w = {imm[11:0], rs1,
                         (opc == OP_ADDI) ? F3_ADD : (opc == OP_ANDI) ? F3_AND : F3_OR,
                         rd, OPC_ITYPE};
                    e = !in_range(imm, -2048, 2047);
                end
                OP_LOAD: begin
                    w = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
                    e = !in_range(imm, -2048, 2047);
                end
                OP_STORE: begin
                    w = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
                    e = !in_range(imm, -2048, 2047);
                end
                OP_BEQ: begin
                    w = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                    e = imm[0] || !in_range(imm, -4096, 4094);
                end
                OP_JAL: begin
                    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                    e = imm[0] || !in_range(imm, -1048576, 1048574);
                end
                OP_LUI: begin
                    w = {imm[31:12], rd, OPC_LUI};
                    e = (imm[11:0] != 12'h000);
                end
                default: e = 1'b1;
            endcase
        end else begin
            case (opc)
                OP_ADD:   w = {ARM_COND, 3'b000, CMD_ADD, 1'b0, rs1[3:0], rd[3:0], 8'h00, rs2[3:0]};
                OP_SUB:   w = {ARM_COND, 3'b000, CMD_SUB, 1'b0, rs1[3:0], rd[3:0], 8'h00, rs2[3:0]};
                OP_AND:   w = {ARM_COND, 3'b000, CMD_AND, 1'b0, rs1[3:0], rd[3:0], 8'h00, rs2[3:0]};
                OP_OR:    w = {ARM_COND, 3'b000, CMD_ORR, 1'b0, rs1[3:0], rd[3:0], 8'h00, rs2[3:0]};
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    w = {ARM_COND, 3'b001,
                         (opc == OP_ADDI) ? CMD_ADD : (opc == OP_ANDI) ? CMD_AND : CMD_ORR,
                         1'b0, rs1[3:0], rd[3:0], 4'h0, imm[7:0]};
                    e = (imm[31:8] != 24'h0);
                end
                OP_LOAD: begin
                    w = {ARM_COND, ARM_LDR, rs1[3:0], rd[3:0], imm[11:0]};
                    e = (imm[31:12] != 20'h0);
                end
                OP_STORE: begin
                    // STR carries the data register in the Rd slot
                    w = {ARM_COND, ARM_STR, rs1[3:0], rs2[3:0], imm[11:0]};
                    e = (imm[31:12] != 20'h0);
                end
                OP_BEQ: begin
                    w = {ARM_COND, ARM_B, imm[25:2]};
                    e = (imm[1:0] != 2'b00) || !in_range(imm, -33554432, 33554428);
                end
                default: e = 1'b1;
            endcase
            if (rd[4] || rs1[4] || rs2[4]) e = 1'b1;
        end
        err   = e;
        instr = e ? 32'h0 : w;
    end

endmodule

// File: rtl/combi_encoder.sv
// Encoder top: request handshake, 2-entry output FIFO, address counter and error counter.
module combi_encoder
    import combi_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_arm,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_arm,
    output logic        out_err,
    input  logic        clr,
    output logic [7:0]  err_cnt
);

    fifo_entry_t mem [2];
    fifo_entry_t enc;
    fifo_entry_t head;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [31:0] addr_cnt;
    logic        push;
    logic        pop;

    combi_enc_word u_word (
        .arm   (req_arm),
        .op    (req_op),
        .rd    (req_rd),
        .rs1   (req_rs1),
        .rs2   (req_rs2),
        .imm   (req_imm),
        .instr (enc.instr),
        .err   (enc.err)
    );
    assign enc.arm = req_arm;

    // Reset gates ready directly so it is low throughout reset and high right after release.
    assign req_ready = reset && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = req_valid && req_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];
    assign out_instr = out_valid ? head.instr : 32'h0;
    assign out_arm   = out_valid ? head.arm : 1'b0;
    assign out_err   = out_valid ? head.err : 1'b0;
    assign out_addr  = addr_cnt;

    // FIFO storage; contents are don't-care while the entry is not valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Address of the head word advances on every handshake; clr takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt <= BASE_ADDR;
        end else if (clr) begin
            addr_cnt <= BASE_ADDR;
        end else if (pop) begin
            addr_cnt <= addr_cnt + 32'd4;
        end
    end

    // Saturating count of error words handed to the consumer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= 8'd0;
        end else if (clr) begin
            err_cnt <= 8'd0;
        end else if (pop && head.err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_combi_encoder.sv
// Self-checking bench for combi_encoder: vector table plus scoreboard and cycle model.
module tb_combi_encoder;
    import combi_enc_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_arm = 1'b0, out_ready = 1'b0, clr = 1'b0;
    logic [3:0]  req_op = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        req_ready, out_valid, out_arm, out_err;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_cnt;

    combi_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_arm(req_arm), .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_arm(out_arm), .out_err(out_err),
        .clr(clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        arm;
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        arm;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur_exp;
    int   n_checks = 0, n_errors = 0, n_acc = 0;
    int   m_cnt = 0, m_err = 0;
    logic [31:0] m_addr = BASE;
    bit   prev_stall = 0, prev_clr = 0;
    exp_t prev_word;
    logic [31:0] prev_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic a, input logic [3:0] o, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] i, input logic [31:0] w, input logic e);
        vec_t v;
        v.arm = a; v.op = o; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.imm = i; v.instr = w; v.err = e;
        return v;
    endfunction

    // Cycle model and scoreboard; sampled mid-cycle, so values seen here are those at the next edge.
    always @(negedge clk) begin
        bit pop, push;
        if (!rst_n) begin
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_ready", req_ready, 1'b0);
            chk("rst_instr", out_instr, 32'h0);
            chk("rst_arm_err", {out_arm, out_err}, 2'b00);
            chk("rst_addr", out_addr, BASE);
            chk("rst_errcnt", err_cnt, 8'd0);
            sb.delete();
            m_cnt = 0; m_addr = BASE; m_err = 0; prev_stall = 0; prev_clr = 0;
        end else begin
            chk("valid_vs_model", out_valid, (m_cnt != 0));
            chk("ready_vs_model", req_ready, (m_cnt < 2));
            chk("addr_vs_model", out_addr, m_addr);
            chk("errcnt_vs_model", err_cnt, m_err[7:0]);
            if (prev_stall && out_valid) begin
                chk("stable_word", {out_instr, out_arm, out_err}, prev_word);
                if (!prev_clr) chk("stable_addr", out_addr, prev_addr);
            end
            pop  = out_valid && out_ready;
            push = req_valid && req_ready;
            if (pop) begin
                if (sb.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL sb_underflow: unexpected word %h at %0t", out_instr, $time);
                end else begin
                    chk("word_instr", out_instr, sb[0].instr);
                    chk("word_arm_err", {out_arm, out_err}, {sb[0].arm, sb[0].err});
                    if (sb[0].err && m_err < 255) m_err++;
                    void'(sb.pop_front());
                end
                m_addr = m_addr + 32'd4;
            end
            if (push) begin
                sb.push_back(cur_exp);
                n_acc++;
            end
            m_cnt = m_cnt + int'(push) - int'(pop);
            if (clr) begin
                m_addr = BASE;
                m_err  = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_instr, out_arm, out_err};
            prev_addr  = out_addr;
            prev_clr   = clr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1'b1;
        req_arm = v.arm; req_op = v.op; req_rd = v.rd;
        req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
        cur_exp.instr = v.err ? 32'h0 : v.instr;
        cur_exp.arm   = v.arm;
        cur_exp.err   = v.err;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 8 && (sb.size() != 0 || out_valid); i++) step();
        chk(name, sb.size(), 0);
    endtask

    initial begin
        vecs.push_back(mk(0, OP_ADD,   5,  6, 7, 32'd0,        32'h007302B3, 0));
        vecs.push_back(mk(0, OP_SUB,   1,  2, 3, 32'd0,        32'h403100B3, 0));
        vecs.push_back(mk(0, OP_SLT,   3,  4, 5, 32'd0,        32'h005221B3, 0));
        vecs.push_back(mk(0, OP_ADDI,  1,  2, 0, -32'sd1,      32'hFFF10093, 0));
        vecs.push_back(mk(0, OP_ADDI,  1,  2, 0, -32'sd2049,   32'h0,        1));
        vecs.push_back(mk(0, OP_ADDI,  1,  0, 0, 32'd2047,     32'h7FF00093, 0));
        vecs.push_back(mk(0, OP_LOAD,  5, 10, 0, 32'd16,       32'h01052283, 0));
        vecs.push_back(mk(0, OP_STORE, 0,  2, 3, 32'd8,        32'h00312423, 0));
        vecs.push_back(mk(0, OP_BEQ,   0,  1, 2, 32'd8,        32'h00208463, 0));
        vecs.push_back(mk(0, OP_BEQ,   0,  1, 2, 32'd7,        32'h0,        1));
        vecs.push_back(mk(0, OP_JAL,   1,  0, 0, 32'd2048,     32'h001000EF, 0));
        vecs.push_back(mk(0, OP_LUI,   1,  0, 0, 32'h12345000, 32'h123450B7, 0));
        vecs.push_back(mk(0, OP_LUI,   1,  0, 0, 32'h12345001, 32'h0,        1));
        vecs.push_back(mk(1, OP_SUB,   1,  2, 3, 32'd0,        32'hE0421003, 0));
        vecs.push_back(mk(1, OP_LOAD,  1,  2, 0, 32'd8,        32'hE5921008, 0));
        vecs.push_back(mk(1, OP_ADDI,  1,  2, 0, 32'd256,      32'h0,        1));
        vecs.push_back(mk(1, OP_ADD,   1,  2, 3, 32'd0,        32'hE0821003, 0));
        vecs.push_back(mk(1, OP_ORI,   4,  5, 0, 32'hFF,       32'hE38540FF, 0));
        vecs.push_back(mk(1, OP_STORE, 0,  2, 3, 32'd4095,     32'hE5823FFF, 0));
        vecs.push_back(mk(1, OP_BEQ,   0,  0, 0, 32'd8,        32'hEA000002, 0));
        vecs.push_back(mk(1, OP_BEQ,   0,  0, 0, -32'sd4,      32'hEAFFFFFF, 0));
        vecs.push_back(mk(1, OP_SLT,   1,  2, 3, 32'd0,        32'h0,        1));
        vecs.push_back(mk(1, OP_ADD,  16,  2, 3, 32'd0,        32'h0,        1));
        vecs.push_back(mk(1, OP_BEQ,   0,  0, 0, 32'd6,        32'h0,        1));
        vecs.push_back(mk(0, 4'd13,    1,  2, 3, 32'd0,        32'h0,        1));
        vecs.push_back(mk(1, OP_AND,   1,  2, 3, 32'd0,        32'hE0021003, 0));
        vecs.push_back(mk(0, OP_BEQ,   0,  0, 0, 32'd4094,     32'h7E000FE3, 0));
        vecs.push_back(mk(0, OP_BEQ,   0,  0, 0, 32'd4096,     32'h0,        1));
        vecs.push_back(mk(0, OP_ADDI,  0,  0, 0, -32'sd2048,   32'h80000013, 0));

        // Reset and release
        repeat (3) step();
        chk("rst_valid_direct", out_valid, 1'b0);
        rst_n = 1'b1;
        #1 chk("ready_after_release", req_ready, 1'b1);

        // First request: word visible one cycle after accept at BASE
        out_ready = 1'b1;
        drive(vecs[0]);
        step();
        chk("first_valid", out_valid, 1'b1);
        chk("first_instr", out_instr, 32'h007302B3);
        chk("first_addr", out_addr, BASE);

        // Table sweep, one request per cycle with the consumer always ready
        for (int i = 1; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
        end
        drain("table_drained");

        // Back-pressure: consumer stalls, four requests offered
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b1;
            drive(vecs[i + 13]);
            if (i == 3) #1 chk("full_ready_low", req_ready, 1'b0);
            step();
        end
        idle();
        chk("stall_accepts", n_acc, 2);
        drain("stall_drained");

        // clr while a word is held must not drop it
        out_ready = 1'b0;
        drive(vecs[1]);
        step();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_keeps_word", out_valid, 1'b1);
        chk("clr_keeps_instr", out_instr, 32'h403100B3);
        drain("clr_drained");

        // Error counter saturation
        out_ready = 1'b1;
        repeat (270) begin
            drive(vecs[24]);
            step();
        end
        drain("sat_drained");
        chk("err_sat", err_cnt, 8'd255);

        // clr coincident with a handshake
        drive(vecs[0]);
        step();
        idle();
        chk("pre_clr_valid", out_valid, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_hs_addr", out_addr, BASE);
        chk("clr_hs_errcnt", err_cnt, 8'd0);
        drive(vecs[13]);
        step();
        idle();
        chk("after_clr_addr", out_addr, BASE);
        drain("clr_hs_drained");

        // Reset with two words held
        out_ready = 1'b0;
        drive(vecs[1]);
        step();
        drive(vecs[2]);
        step();
        idle();
        chk("held_two", {out_valid, req_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", req_ready, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(vecs[14]);
        step();
        idle();
        chk("post_rst_instr", out_instr, 32'hE5921008);
        chk("post_rst_addr", out_addr, BASE);
        drain("final_drained");

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
